// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int WORD_W    = ADDR_SIZE + 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

  // Command field values carried in rx_data[9:8]; decoded by the RAM.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Loads a read byte and shifts it out on miso MSB first, one bit per clock.
// miso is held at 0 whenever no byte is being shifted.
module spi_tx_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         abort,
  input  logic [W-1:0] data,
  output logic         miso
);

  localparam int CW = $clog2(W);

  // sr holds the bits still to be sent, next one in the MSB.
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          busy;

  // Load puts the MSB on miso immediately; each later cycle presents the next bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      miso <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      busy <= 1'b0;
      miso <= 1'b0;
    end else if (load) begin
      sr   <= {data[W-2:0], 1'b0};
      miso <= data[W-1];
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == CW'(W-1)) begin
        busy <= 1'b0;
        cnt  <= '0;
        miso <= 1'b0;
      end else begin
        miso <= sr[W-1];
        sr   <= {sr[W-2:0], 1'b0};
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI into command/data words for the RAM
// stage and serialises the RAM read byte back out on MISO.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  import spi_pkg::*;

  localparam int W  = ADDR_SIZE + 2;
  localparam int NB = W - 1;            // bits received after the command bit
  localparam int CW = $clog2(NB + 1);   // counter also holds the "done" value NB

  spi_state_e     state, state_nxt;
  logic [NB-1:0]  sr;
  logic [CW-1:0]  cnt;
  logic           addr_done;
  logic           tx_taken;
  logic           rx_phase;
  logic           frame_done;
  logic           tx_load;

  // Next-state selection plus frame-complete and tx-load decodes.
  always_comb begin
    state_nxt  = state;
    rx_phase   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    frame_done = 1'b0;
    tx_load    = 1'b0;
    case (state)
      IDLE:    if (!ss_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (ss_n)       state_nxt = IDLE;
        else if (!mosi) state_nxt = WRITE;
        else            state_nxt = addr_done ? READ_DATA : READ_ADD;
      end
      default: if (ss_n) state_nxt = IDLE;
    endcase
    frame_done = rx_phase && !ss_n && (cnt == CW'(NB-1));
    tx_load    = (state == READ_DATA) && !ss_n && (cnt == CW'(NB)) &&
                 !tx_taken && tx_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Receive shift/count, word hand-off, read-address tracking, one tx load per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      addr_done <= 1'b0;
      tx_taken  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n || state == IDLE) begin
        cnt      <= '0;
        tx_taken <= 1'b0;
      end else if (state == CHK_CMD) begin
        sr  <= {sr[NB-2:0], mosi};
        cnt <= '0;
      end else if (cnt != CW'(NB)) begin
        sr  <= {sr[NB-2:0], mosi};
        cnt <= cnt + 1'b1;
      end
      if (frame_done) begin
        rx_data  <= {sr, mosi};
        rx_valid <= 1'b1;
        if (state == READ_ADD)  addr_done <= 1'b1;
        if (state == READ_DATA) addr_done <= 1'b0;
      end
      if (tx_load) tx_taken <= 1'b1;
    end
  end

  spi_tx_serializer #(.W(ADDR_SIZE)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .abort (ss_n),
    .data  (tx_data),
    .miso  (miso)
  );

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: scoreboarded rx words, cycle-exact miso checks.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ss_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data = 8'h00;
  logic              tx_valid = 1'b0;

  spi_slave_if #(.ADDR_SIZE(ADDR_SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [WORD_W-1:0] exp_q[$];
  int                exp_cyc_q[$];
  logic [7:0]        mem [256];
  logic [7:0]        wr_addr = 8'h00;
  logic [7:0]        rd_addr = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scoreboard: each strobe must match the oldest expected word and its cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      chk("rx_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [WORD_W-1:0] w;
        int c;
        w = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(w));
        chk("rx_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  // RAM model: tracks what the RAM would do with each completed word.
  task automatic apply_model(input logic [WORD_W-1:0] w);
    case (w[9:8])
      CMD_WR_ADDR: wr_addr = w[7:0];
      CMD_WR_DATA: mem[wr_addr] = w[7:0];
      CMD_RD_ADDR: rd_addr = w[7:0];
      default: ;
    endcase
  endtask

  // Drive a full frame from cycle 0; returns during cycle 11 (strobe cycle).
  task automatic send_frame(input logic [WORD_W-1:0] w);
    ss_n = 1'b0;
    for (int i = WORD_W-1; i >= 0; i--) begin
      tick;
      mosi = w[i];
    end
    exp_q.push_back(w);
    exp_cyc_q.push_back(cyc + 1);
    apply_model(w);
    tick;
    mosi = 1'b0;
  endtask

  task automatic end_frame;
    ss_n = 1'b1;
    tick;
    tick;
  endtask

  // From cycle 11 of a read-data frame: present the RAM byte at cycle 12 for
  // 'hold' cycles and check miso for 'nbits' bits (plus trailing zeros if all 8).
  task automatic read_byte(input int hold, input int nbits);
    logic [7:0] b;
    b = mem[rd_addr];
    tick;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int k = 1; k <= nbits; k++) begin
      tick;
      tx_valid = (k < hold);
      chk("miso_bit", 32'(miso), 32'(b[8-k]));
    end
    if (nbits == 8) begin
      for (int k = 9; k <= 20; k++) begin
        tick;
        tx_valid = (k < hold);
        chk("miso_idle", 32'(miso), 32'd0);
      end
      tx_valid = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    rst_n = 1'b0;
    tick; tick; tick;
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_addr_done", 32'(dut.addr_done), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    tick;

    // Write address
    send_frame(10'h005);
    chk("wa_miso", 32'(miso), 32'd0);
    tick;
    chk("wa_miso2", 32'(miso), 32'd0);
    end_frame;
    chk("wa_addr_done", 32'(dut.addr_done), 32'd0);

    // Write data
    send_frame(10'h1AA);
    end_frame;

    // Read sequence: address then data, byte 0xAA returned
    send_frame(10'h205);
    chk("ra_state", 32'(dut.state), 32'(READ_ADD));
    chk("ra_addr_done", 32'(dut.addr_done), 32'd1);
    end_frame;
    chk("ra_addr_done_kept", 32'(dut.addr_done), 32'd1);
    send_frame(10'h300);
    chk("rd_state", 32'(dut.state), 32'(READ_DATA));
    chk("rd_addr_done", 32'(dut.addr_done), 32'd0);
    read_byte(1, 8);
    end_frame;

    // Abort after 5 bits, then a clean frame
    ss_n = 1'b0;
    for (int i = 9; i >= 5; i--) begin
      tick;
      mosi = 1'(10'h3FF >> i);
    end
    tick;
    ss_n = 1'b1;
    mosi = 1'b0;
    tick; tick;
    chk("ab_state", 32'(dut.state), 32'(IDLE));
    chk("ab_addr_done", 32'(dut.addr_done), 32'd0);
    send_frame(10'h0F0);
    end_frame;

    // Sticky tx_valid: byte shifted exactly once
    send_frame(10'h13C);
    end_frame;
    send_frame(10'h2F0);
    end_frame;
    send_frame(10'h300);
    read_byte(20, 8);
    end_frame;

    // Reset mid-shift after 3 bits
    send_frame(10'h2F0);
    end_frame;
    send_frame(10'h300);
    read_byte(1, 3);
    rst_n = 1'b0;
    tick;
    chk("mr_miso", 32'(miso), 32'd0);
    chk("mr_rx_valid", 32'(rx_valid), 32'd0);
    chk("mr_addr_done", 32'(dut.addr_done), 32'd0);
    rst_n    = 1'b1;
    ss_n     = 1'b1;
    tx_valid = 1'b0;
    tick; tick;
    send_frame(10'h300);
    chk("mr_next_state", 32'(dut.state), 32'(READ_ADD));
    chk("mr_next_addr_done", 32'(dut.addr_done), 32'd1);
    end_frame;

    // Reset while addr_done is set clears it
    rst_n = 1'b0;
    tick;
    chk("rr_addr_done", 32'(dut.addr_done), 32'd0);
    rst_n = 1'b1;
    tick;
    send_frame(10'h300);
    chk("rr_next_state", 32'(dut.state), 32'(READ_ADD));
    end_frame;

    chk("rx_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
